// File: rtl/branch_predictor.sv
// Fetch-stage direction predictor with a table of 2-bit saturating counters.
// The decode-stage outcome trains the table, and the resolved/mispredict counts are kept for debug.
module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       pcF,
    input  logic              branchF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              branchD,
    input  logic              actual_takenD,
    output logic              pred_takenF,
    output logic              pred_takenD,
    output logic              mispredictD,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    typedef struct packed {
        logic             pred_taken;
        logic [IDX_W-1:0] idx;
        logic             valid;
    } fd_t;

    logic [1:0]       pht [DEPTH];
    logic [IDX_W-1:0] idx_f;
    fd_t              fd_q;
    fd_t              fd_d;
    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_nxt;
    logic             update;

    // The PC bits outside the index field take no part in the lookup, because the table has no tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcF[31:IDX_W+2], pcF[1:0]};

    assign idx_f       = pcF[IDX_W+1:2];
    assign pred_takenF = branchF & pht[idx_f][1];
    assign pred_takenD = fd_q.pred_taken;
    assign mispredictD = branchD & fd_q.valid & (fd_q.pred_taken != actual_takenD);
    assign update      = branchD & ~stallD;
    assign fd_d        = '{pred_taken: pred_takenF, idx: idx_f, valid: branchF};

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_cur = pht[fd_q.idx];
        cnt_nxt = cnt_cur;
        if (actual_takenD) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
        end else if (cnt_cur != 2'b00) begin
            cnt_nxt = cnt_cur - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every reader sees the value from before the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fd_q <= '0;
        end else if (flushD) begin
            fd_q <= '0;
        end else if (!stallD) begin
            fd_q <= fd_d;
        end
    end

    // NOTE: the table is built from flops rather than a RAM, because every entry must return to CNT_INIT on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) pht[i] <= CNT_INIT;
        end else if (update) begin
            pht[fd_q.idx] <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (update) begin
            branch_cnt <= branch_cnt + 1'b1;
            if (mispredictD) mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a model of integer counters.
// The model keeps the F->D slot as plain fields.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pcF = '0;
    logic        branchF = 1'b0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        branchD = 1'b0;
    logic        actual_takenD = 1'b0;
    logic        pred_takenF;
    logic        pred_takenD;
    logic        mispredictD;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int total = 0;
    int bad = 0;

    // Reference model: each counter is an integer in 0..3 and predicts taken at 2 or above.
    int          pht_m [64];
    bit          m_valid;
    bit          m_pred;
    int          m_idx;
    int unsigned m_br;
    int unsigned m_mis;

    branch_predictor dut (
        .clk          (clk),
        .resetn       (resetn),
        .pcF          (pcF),
        .branchF      (branchF),
        .stallD       (stallD),
        .flushD       (flushD),
        .branchD      (branchD),
        .actual_takenD(actual_takenD),
        .pred_takenF  (pred_takenF),
        .pred_takenD  (pred_takenD),
        .mispredictD  (mispredictD),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) pht_m[i] = 1;
        m_valid = 0;
        m_pred  = 0;
        m_idx   = 0;
        m_br    = 0;
        m_mis   = 0;
    endfunction

    task automatic check_all(input string tag);
        bit exp_f;
        bit exp_mis;
        exp_f   = branchF && (pht_m[idx_of(pcF)] >= 2);
        exp_mis = branchD && m_valid && (m_pred != actual_takenD);
        check({tag, ".predF"}, pred_takenF, exp_f);
        check({tag, ".predD"}, pred_takenD, m_pred);
        check({tag, ".misD"}, mispredictD, exp_mis);
        check({tag, ".brcnt"}, branch_cnt, m_br);
        check({tag, ".miscnt"}, mispred_cnt, m_mis);
    endtask

    // Drives one cycle from a negedge, checks the outputs, then advances the model across the posedge.
    task automatic cycle(input string tag, input logic [31:0] pc, input bit bf, input bit st,
                         input bit fl, input bit bd, input bit at);
        bit f_pred;
        bit mis;
        pcF = pc; branchF = bf; stallD = st; flushD = fl; branchD = bd; actual_takenD = at;
        #1;
        check_all(tag);
        f_pred = bf && (pht_m[idx_of(pc)] >= 2);
        mis    = bd && m_valid && (m_pred != at);
        @(posedge clk);
        if (bd && !st) begin
            if (at) pht_m[m_idx] = (pht_m[m_idx] == 3) ? 3 : pht_m[m_idx] + 1;
            else    pht_m[m_idx] = (pht_m[m_idx] == 0) ? 0 : pht_m[m_idx] - 1;
            m_br++;
            if (mis) m_mis++;
        end
        if (fl) begin
            m_valid = 0; m_pred = 0; m_idx = 0;
        end else if (!st) begin
            m_valid = bf; m_pred = f_pred; m_idx = idx_of(pc);
        end
        @(negedge clk);
    endtask

    // Resets in mid-cycle while a taken branch is waiting to update, so that the update must be lost.
    task automatic do_reset(input string tag);
        pcF = 32'h100; branchF = 1; branchD = 1; actual_takenD = 1; stallD = 0; flushD = 0;
        #2 resetn = 0;
        model_reset();
        #1;
        check_all({tag, ".in"});
        @(posedge clk);
        #1;
        check_all({tag, ".edge"});
        @(negedge clk);
        resetn = 1;
        branchD = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset("rst0");

        // A fresh entry at 0x100 predicts not-taken in F and D.
        cycle("t1a", 32'h100, 1, 0, 0, 0, 0);
        // The first taken resolution is a mispredict. The second one is not.
        cycle("t2a", 32'h000, 0, 0, 0, 1, 1);
        cycle("t2b", 32'h100, 1, 0, 0, 0, 0);
        cycle("t2c", 32'h000, 0, 0, 0, 1, 1);
        cycle("t2d", 32'h100, 1, 0, 0, 0, 0);
        check("t2.brcnt_is_2", branch_cnt, 2);
        check("t2.miscnt_is_1", mispred_cnt, 1);
        check("t2.predF_taken", pred_takenF, 1);

        // Four not-taken resolutions move the counter down and hold it at 0.
        for (int i = 0; i < 4; i++) begin
            cycle("t3f", 32'h100, 1, 0, 0, 0, 0);
            cycle("t3r", 32'h000, 0, 0, 0, 1, 0);
        end

        // A stalled branch updates only once, in the cycle it leaves D.
        cycle("t4f", 32'h104, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("t4s", 32'h108, 1, 1, 0, 1, 1);
        cycle("t4go", 32'h000, 0, 0, 0, 1, 1);
        cycle("t4after", 32'h104, 1, 0, 0, 0, 0);

        // When flush and stall are both set, flush wins and D becomes empty.
        cycle("t5f", 32'h000, 0, 0, 0, 1, 1);
        cycle("t5fl", 32'h10c, 1, 1, 1, 1, 1);
        cycle("t5e", 32'h000, 0, 0, 0, 0, 1);

        // A lookup in the same cycle as an update of the same entry reads the old value. 0x200 aliases 0x100.
        do_reset("rst1");
        cycle("t6a", 32'h100, 1, 0, 0, 0, 0);
        cycle("t6b", 32'h100, 1, 0, 0, 1, 1);
        cycle("t6c", 32'h200, 1, 0, 0, 1, 1);
        cycle("t6d", 32'h200, 1, 0, 0, 1, 0);
        do_reset("rst2");
        cycle("t6z", 32'h200, 1, 0, 0, 0, 0);

        // Random traffic over a small set of indices, with aliasing PCs, stalls and flushes.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            bit bf, st, fl, at;
            pc = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8);
            bf = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 9) == 0);
            at = $urandom_range(0, 1) == 1;
            cycle("rnd", pc, bf, st, fl, m_valid, at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
